// File: rtl/avalon_st_pkt_pkg.sv
// Shared types and the CRC-8 step used by the Avalon-ST packet checker.
package avalon_st_pkt_pkg;

  typedef enum logic [1:0] {
    CRC      = 2'd0,
    RXERR    = 2'd1,
    FRAMING  = 2'd2,
    OVERFLOW = 2'd3
  } drop_reason_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    DISCARD = 2'd2
  } state_e;

  // One byte through an MSB-first CRC-8, no reflection, no final XOR.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                           input logic [7:0] data,
                                           input logic [7:0] poly);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ poly) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/avalon_st_packet_checker_pkt_buffer_ram.sv
// Simple dual-port RAM with registered read; maps onto a block RAM.
module pkt_buffer_ram #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 9
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/avalon_st_packet_checker.sv
// Store-and-forward CRC-8 packet filter; only whole, good packets reach the output.
//   state   | meaning
//   IDLE    | between packets, waiting for SOP
//   RECV    | buffering payload, last byte parked in held_q
//   DISCARD | dropping the rest of a bad packet until EOP or a new SOP
module avalon_st_packet_checker
  import avalon_st_pkt_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 6,
  parameter logic [7:0]  CRC_POLY   = 8'h07
) (
  input  logic       clk,
  input  logic       reset,
  output logic       in_ready,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_startofpacket,
  input  logic       in_endofpacket,
  input  logic       in_error,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_startofpacket,
  output logic       out_endofpacket,
  output logic       good_pulse,
  output logic       drop_pulse,
  output logic [1:0] drop_reason
);

  localparam int unsigned   PW     = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [PW-1:0] ONE    = PW'(1);
  localparam logic [1:0]    S_IDLE = IDLE;
  localparam logic [1:0]    S_RECV = RECV;
  localparam logic [1:0]    S_DISC = DISCARD;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] wr_q, wr_d, cm_q, cm_d, rd_q, f_q;
  logic [7:0]    held_q, held_d, crc_q, crc_d;
  logic          good_q, good_d, drop_q, drop_d;
  logic [1:0]    reason_q;
  drop_reason_e  reason_d;
  logic          we, full;
  logic [8:0]    wdata, ram_q;

  assign in_ready = 1'b1;
  // rd_q only moves on a transferred beat, so bytes still in the read pipe hold their slots.
  assign full = (wr_q - rd_q) == DEPTH;

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    cm_d     = cm_q;
    held_d   = held_q;
    crc_d    = crc_q;
    good_d   = 1'b0;
    drop_d   = 1'b0;
    reason_d = CRC;
    we       = 1'b0;
    wdata    = {1'b0, held_q};
    if (in_valid) begin
      if (in_startofpacket && !in_error && !in_endofpacket) begin
        if (state_q == S_RECV) begin
          drop_d   = 1'b1;
          reason_d = FRAMING;
        end
        wr_d    = cm_q;
        held_d  = in_data;
        crc_d   = crc8_step(8'h00, in_data, CRC_POLY);
        state_d = S_RECV;
      end else if (in_startofpacket && in_endofpacket && !in_error) begin
        drop_d   = 1'b1;
        reason_d = FRAMING;
        wr_d     = cm_q;
        state_d  = S_IDLE;
      end else if (in_error && state_q != S_DISC) begin
        drop_d   = 1'b1;
        reason_d = RXERR;
        wr_d     = cm_q;
        state_d  = in_endofpacket ? S_IDLE : S_DISC;
      end else begin
        case (state_q)
          S_IDLE: begin
            drop_d   = 1'b1;
            reason_d = FRAMING;
            if (!in_endofpacket) state_d = S_DISC;
          end
          S_RECV: begin
            if (!in_endofpacket) begin
              if (full) begin
                drop_d   = 1'b1;
                reason_d = OVERFLOW;
                wr_d     = cm_q;
                state_d  = S_DISC;
              end else begin
                we     = 1'b1;
                wr_d   = wr_q + ONE;
                held_d = in_data;
                crc_d  = crc8_step(crc_q, in_data, CRC_POLY);
              end
            end else if (in_data != crc_q) begin
              drop_d   = 1'b1;
              reason_d = CRC;
              wr_d     = cm_q;
              state_d  = S_IDLE;
            end else if (full) begin
              drop_d   = 1'b1;
              reason_d = OVERFLOW;
              wr_d     = cm_q;
              state_d  = S_IDLE;
            end else begin
              we      = 1'b1;
              wdata   = {1'b1, held_q};
              wr_d    = wr_q + ONE;
              cm_d    = wr_q + ONE;
              good_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
          default: if (in_endofpacket) state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_q     <= '0;
      cm_q     <= '0;
      held_q   <= '0;
      crc_q    <= '0;
      good_q   <= 1'b0;
      drop_q   <= 1'b0;
      reason_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      cm_q     <= cm_d;
      held_q   <= held_d;
      crc_q    <= crc_d;
      good_q   <= good_d;
      drop_q   <= drop_d;
      reason_q <= reason_d;
    end
  end

  assign good_pulse  = good_q;
  assign drop_pulse  = drop_q;
  assign drop_reason = reason_q;

  // Read side: RAM output stage (s1) feeding the show-ahead output register.
  logic       s1_vld_q, s1_take, re;
  logic       out_valid_q, out_eop_q, sop_pend_q;
  logic [7:0] out_data_q;

  assign s1_take = s1_vld_q && (!out_valid_q || out_ready);
  assign re      = (f_q != cm_q) && (!s1_vld_q || s1_take);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_q         <= '0;
      rd_q        <= '0;
      s1_vld_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_eop_q   <= 1'b0;
      sop_pend_q  <= 1'b1;
    end else begin
      if (re) f_q <= f_q + ONE;
      if (re) s1_vld_q <= 1'b1;
      else if (s1_take) s1_vld_q <= 1'b0;
      if (out_valid_q && out_ready) begin
        rd_q       <= rd_q + ONE;
        sop_pend_q <= out_eop_q;
      end
      if (!out_valid_q || out_ready) begin
        out_valid_q <= s1_vld_q;
        if (s1_vld_q) {out_eop_q, out_data_q} <= ram_q;
      end
    end
  end

  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign out_endofpacket   = out_valid_q & out_eop_q;
  assign out_startofpacket = out_valid_q & sop_pend_q;

  pkt_buffer_ram #(.AW(DEPTH_LOG2), .DW(9)) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wr_q[DEPTH_LOG2-1:0]),
    .wdata_i (wdata),
    .re_i    (re),
    .raddr_i (f_q[DEPTH_LOG2-1:0]),
    .rdata_o (ram_q)
  );

endmodule

// File: doc/avalon_st_packet_checker.md
Name: avalon_st_packet_checker

Overview:
Store-and-forward packet filter placed directly downstream of the UART bridge's Avalon-ST source.
- Buffers each received packet, verifies framing and a trailing CRC-8, and forwards only good packets with the CRC byte stripped.
- Rewinds the buffer to drop bad, aborted or oversize packets, so downstream logic never sees a partial packet.
- Never backpressures, because the UART receive path cannot be stalled.

Parameters:
DEPTH_LOG2, 6, buffer holds 2**DEPTH_LOG2 payload bytes; this is also the maximum payload length.
CRC_POLY, 8'h07, CRC-8 polynomial, init 8'h00, MSB-first, no reflection, no final XOR.

Ports:
clk  in  1  clock
reset  in  1  reset
in_ready  out  1  constant 1 after reset
in_valid  in  1  input beat valid
in_data  in  8  input byte
in_startofpacket  in  1  input SOP
in_endofpacket  in  1  input EOP
in_error  in  1  receive error (framing/break) flag on beat
out_ready  in  1  downstream ready (ready latency 0)
out_valid  out  1  output beat valid
out_data  out  8  payload byte
out_startofpacket  out  1  output SOP
out_endofpacket  out  1  output EOP (last payload byte)
good_pulse  out  1  one-cycle pulse when a packet is committed
drop_pulse  out  1  one-cycle pulse when a packet is dropped
drop_reason  out  2  0 CRC mismatch, 1 in_error, 2 framing/short, 3 overflow; valid with drop_pulse

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk. All outputs are 0 during reset except in_ready. Pointers, held byte, CRC and state clear. Asserting reset mid-operation loses all buffered data, committed packets included.
- Packet format: N≥1 payload bytes followed by 1 CRC byte; the EOP beat carries the CRC. The CRC is computed over the payload only.
- Buffer: 2**DEPTH_LOG2 × 9-bit memory ({eop_flag, data}). Pointers are DEPTH_LOG2+1 bits wide: rd_ptr, wr_ptr (speculative), cm_ptr (committed).
  - Full when wr_ptr - rd_ptr == 2**DEPTH_LOG2.
  - Rewind: wr_ptr <= cm_ptr.
- One-byte hold register: each payload byte is written to memory only when the next beat arrives. This lets the final payload byte be written with eop_flag=1 when the CRC beat arrives.
- FSM states: IDLE, RECV, DISCARD. Each rule below applies on an in_valid beat.
  - Any state, SOP beat with in_error=0 and in_endofpacket=0: start a new packet.
    - If the state was RECV, first drop the old packet (reason 2) and rewind.
    - Then: held=data, crc=crc8(0,data), go to RECV.
  - SOP+EOP beat with in_error=0: drop (reason 2), go to IDLE.
  - Any beat with in_error=1 while in IDLE or RECV: drop (reason 1) and rewind. Go to IDLE if EOP, else DISCARD.
  - IDLE, non-SOP beat: drop (reason 2), go to DISCARD unless EOP.
  - RECV, middle beat (no SOP/EOP/error):
    - If not full: write {0,held}, wr_ptr++, held=data, crc=crc8(crc,data).
    - If full: drop (reason 3), rewind, go to DISCARD.
  - RECV, EOP beat:
    - If data==crc and not full: write {1,held}, cm_ptr<=wr_ptr+1, wr_ptr++, good_pulse, go to IDLE.
    - If data≠crc: drop (reason 0), rewind, go to IDLE.
    - If full: drop (reason 3), rewind, go to IDLE.
  - DISCARD: ignore beats until EOP (go to IDLE) or a new SOP (start packet). No additional drop pulse is emitted.
- Output: show-ahead register fed by a synchronous memory read. out_valid is asserted when the register holds a byte read from [rd_ptr, cm_ptr).
  - Latency: CRC beat accepted at edge N → commit at edge N → out_valid high after edge N+2.
  - Sustains 1 byte/cycle while out_ready=1.
  - out_data, SOP and EOP hold stable while out_valid && !out_ready.
- out_startofpacket: 1 on the first beat after reset and on the first beat after a transferred EOP beat.
- Simultaneous commit and read, or rewind and read: allowed. The read side only sees cm_ptr, never speculative data.
- in_valid=0 cycles: no state change.

Decomposition:
- Package avalon_st_pkt_pkg holds:
  - drop_reason_e enum (CRC, RXERR, FRAMING, OVERFLOW)
  - state_e enum (IDLE, RECV, DISCARD)
  - function crc8_step(crc, data, poly)
- One sub-module: pkt_buffer_ram. It is a simple dual-port 9-bit RAM with a registered read, inferred as a block RAM.

Test Plan:
- Good packet: SOP 0x01, 0x02, 0x03, EOP 0x48 → out 01(SOP),02,03(EOP); good_pulse ×1; out_valid first high 2 cycles after the EOP beat.
- Bad CRC: 0x01, 0x02, 0x03, EOP 0x49 → no output; drop_pulse with reason 0; a following good packet 0x01, EOP 0x07 → out 01 with SOP=EOP=1.
- Error mid-packet: 0x01, 0x02 with in_error=1, then 0x03, EOP 0x48 → reason 1, no output, no second drop pulse.
- Overflow (DEPTH_LOG2=2): 5-byte payload → reason 3. A 4-byte payload with correct CRC passes. A 4-byte payload while an unread 1-byte packet is still buffered → reason 3 and the buffered packet survives intact.
- Abort and backpressure: SOP 0xAA, 0xBB, then new SOP 0x01, EOP 0x07 → reason 2, then out 01. Then two good packets with out_ready toggling 1010… → bytes in order, SOP/EOP correct, nothing duplicated.
- Reset asserted while a committed packet is partially read → all outputs 0, no residual bytes after release.
